// File: rtl/sig_capture_pkg.sv
// Shared types and defaults for the compliance-signature capture block.
package sig_capture_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_SIG_ADDR  = 32'h0000_0F00;
    localparam logic [XLEN-1:0] DEFAULT_HALT_ADDR = 32'hCAFE_BEEF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sig_capture_unit_if.sv
// Store-side and drain-side signals of the signature capture block.
interface sig_capture_unit_if;
    import sig_capture_pkg::*;

    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;
    logic            out_valid;
    logic [XLEN-1:0] out_data;
    logic            out_ready;

    modport master (
        output st_valid, st_addr, st_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/sig_capture_unit_fifo.sv
// First-word fall-through synchronous FIFO with occupancy, full and empty flags.
module sync_fifo_fwft #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_fwft: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_accept;
    logic             rd_accept;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; only the pointers define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/sig_capture_unit.sv
// Signature capture: buffers stores to SIG_ADDR, stops on a store to HALT_ADDR.
// Define SIG_CAPTURE_TRACE_EN to also capture retiring register writebacks.
module sig_capture_unit
    import sig_capture_pkg::*;
#(
    parameter  int unsigned     DEPTH     = 16,
    parameter  logic [XLEN-1:0] SIG_ADDR  = DEFAULT_SIG_ADDR,
    parameter  logic [XLEN-1:0] HALT_ADDR = DEFAULT_HALT_ADDR,
    parameter  int unsigned     CNT_W     = 16,
    localparam int unsigned     LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    sig_capture_unit_if.slave  bus,
`ifdef SIG_CAPTURE_TRACE_EN
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_result,
`endif
    output logic               halted,
    output logic               done,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [LVL_W-1:0]   level
);

    if (SIG_ADDR == HALT_ADDR) begin : g_bad_addr
        $error("sig_capture_unit: SIG_ADDR and HALT_ADDR must differ");
    end

    cap_state_e      state;
    logic            sig_hit;
    logic            halt_hit;
    logic            pop;
    logic            push;
    logic [XLEN-1:0] push_data;
    logic [1:0]      drop_inc;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNT_W:0]  drop_sum;

    assign sig_hit  = bus.st_valid && (bus.st_addr == SIG_ADDR);
    assign halt_hit = bus.st_valid && (bus.st_addr == HALT_ADDR);

    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push      = 1'b0;
        push_data = bus.st_data;
        drop_inc  = 2'd0;
        if (state == RUN) begin
            if (sig_hit) begin
                push = 1'b1;
                if (fifo_full && !pop) drop_inc = 2'd1;
            end
`ifdef SIG_CAPTURE_TRACE_EN
            // The signature store owns the single write slot; a colliding writeback is lost.
            if (wb_valid && wb_rd != 5'd0) begin
                if (sig_hit) begin
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    push      = 1'b1;
                    push_data = wb_result;
                    if (fifo_full && !pop) drop_inc = 2'd1;
                end
            end
`endif
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (bus.out_ready),
        .rd_data (bus.out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop_inc != 2'd0) begin
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // done is raised in step with the FIFO becoming empty, using the last pop as lookahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            halted <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= DRAIN;
                        halted <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (level == LVL_W'(0) || (level == LVL_W'(1) && pop)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_capture_unit.sv
// Directed bench for sig_capture_unit with the default 16-entry configuration.
module tb_sig_capture_unit;

    localparam logic [31:0] SIG  = 32'h0000_0F00;
    localparam logic [31:0] HALT = 32'hCAFE_BEEF;

    logic        clk;
    logic        rst;
    logic        halted;
    logic        done;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    int total;
    int bad;

    sig_capture_unit_if bus();

    sig_capture_unit dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .halted   (halted),
        .done     (done),
        .drop_cnt (drop_cnt),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_halted",    halted, 0);
        check("rst_done",      done, 0);
        check("rst_drop",      drop_cnt, 0);
        check("rst_level",     level, 0);
        rst = 1'b1;
        tick();

        // Three stores with a ready consumer: each word visible one cycle after its push
        bus.out_ready = 1'b1;
        store(SIG, 1);
        check("seq_d1", bus.out_data, 1);
        check("seq_lvl1", level, 1);
        store(SIG, 2);
        check("seq_d2", bus.out_data, 2);
        store(SIG, 3);
        check("seq_d3", bus.out_data, 3);
        check("seq_lvl3", level, 1);
        tick();
        check("seq_empty_lvl", level, 0);
        check("seq_empty_valid", bus.out_valid, 0);
        check("seq_drop", drop_cnt, 0);

        // Overfill: 20 stores into 16 entries, 4 dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) store(SIG, 100 + i);
        check("full_lvl", level, 16);
        check("full_drop", drop_cnt, 4);
        check("full_head", bus.out_data, 100);

        // Push and pop at full: level holds, no new drop
        bus.out_ready = 1'b1;
        store(SIG, 200);
        check("pp_lvl", level, 16);
        check("pp_drop", drop_cnt, 4);
        for (int k = 0; k < 16; k++) begin
            check("drain_order", bus.out_data, (k < 15) ? 32'(101 + k) : 32'd200);
            tick();
        end
        check("drain_lvl", level, 0);
        check("drain_drop", drop_cnt, 4);

        // Non-matching address and non-valid cycle do not push
        bus.out_ready = 1'b0;
        bus.st_valid  = 1'b1;
        bus.st_addr   = 32'h0000_0F04;
        bus.st_data   = 55;
        tick();
        bus.st_valid  = 1'b0;
        bus.st_addr   = SIG;
        bus.st_data   = 66;
        tick();
        bus.st_addr   = '0;
        check("nopush_lvl", level, 0);
        check("nopush_valid", bus.out_valid, 0);

        // Halt with 5 entries queued; later stores ignored; done after the fifth pop
        for (int i = 0; i < 5; i++) store(SIG, 11 + i);
        check("halt_pre_lvl", level, 5);
        check("halt_pre", halted, 0);
        store(HALT, 32'hDEAD);
        check("halt_set", halted, 1);
        check("halt_not_done", done, 0);
        store(SIG, 77);
        store(SIG, 78);
        check("halt_ignore_lvl", level, 5);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("halt_drain", bus.out_data, 32'(11 + k));
            check("halt_done_low", done, 0);
            tick();
        end
        check("done_set", done, 1);
        check("done_lvl", level, 0);
        check("done_halted", halted, 1);
        tick();
        check("done_sticky", done, 1);

        // Fresh run, then asynchronous reset in the middle of a drain
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) store(SIG, 32'h40 + i);
        check("mid_lvl", level, 8);
        store(HALT, 0);
        check("mid_halted", halted, 1);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("mid_lvl6", level, 6);
        check("mid_head", bus.out_data, 32'h42);
        #2 rst = 1'b0;
        #1;
        check("arst_valid",  bus.out_valid, 0);
        check("arst_data",   bus.out_data, 0);
        check("arst_level",  level, 0);
        check("arst_halted", halted, 0);
        check("arst_done",   done, 0);
        check("arst_drop",   drop_cnt, 0);
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        store(SIG, 32'h99);
        check("post_valid", bus.out_valid, 1);
        check("post_data", bus.out_data, 32'h99);
        check("post_lvl", level, 1);
        bus.out_ready = 1'b1;
        tick();
        check("post_empty", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
